// File: rtl/turn_sequencer.sv
// Turn-level scheduler: sequences draw, shuffle, action, buy and cleanup modes for the card handler.
// All outputs are registered with 1-cycle latency. Every handler mode change passes through a 1-cycle GAP at MODE_IDLE.
module turn_sequencer #(
  parameter int unsigned HAND_SIZE     = 5,
  parameter int unsigned BUYS_PER_TURN = 1,
  parameter logic [2:0]  MODE_IDLE     = 3'd0,
  parameter logic [2:0]  MODE_DRAW     = 3'd1,
  parameter logic [2:0]  MODE_BUY      = 3'd2,
  parameter logic [2:0]  MODE_CLEANUP  = 3'd3,
  parameter logic [2:0]  MODE_SHUFFLE  = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       but_end,
  input  logic       plus_buy,
  input  logic       end_mode,
  input  logic       next_card,
  input  logic [7:0] deck_count,
  input  logic [7:0] discard_count,
  output logic [2:0] mode,
  output logic       can_buy,
  output logic [2:0] phase,
  output logic [3:0] buys_left,
  output logic [7:0] turn_count
);

  localparam logic [3:0] HAND_L = 4'(HAND_SIZE);
  localparam logic [3:0] BUYS_L = 4'(BUYS_PER_TURN);

  // Encodings double as the phase output code.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAW    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_ACTION  = 3'd3,
    S_BUY     = 3'd4,
    S_CLEANUP = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  state_t     state_q, state_d;
  state_t     dest_q, dest_d;
  logic [3:0] draw_left_q, draw_left_d;
  logic [3:0] buys_left_q, buys_left_d;
  logic [7:0] turn_count_q, turn_count_d;
  logic [2:0] mode_q, mode_d;
  logic       can_buy_q, can_buy_d;
  logic [3:0] draw_after;
  logic [3:0] buys_after;

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    draw_left_d  = draw_left_q;
    buys_left_d  = buys_left_q;
    turn_count_d = turn_count_q;
    mode_d       = MODE_IDLE;
    can_buy_d    = 1'b0;

    // A same-cycle card is always counted before any exit decision.
    draw_after = draw_left_q - {3'b000, next_card & (draw_left_q != 4'd0)};
    buys_after = buys_left_q - {3'b000, next_card & (buys_left_q != 4'd0)};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_GAP;
          dest_d      = S_DRAW;
          draw_left_d = HAND_L;
          buys_left_d = BUYS_L;
        end
      end
      S_DRAW: begin
        draw_left_d = draw_after;
        if (end_mode || draw_after == 4'd0) begin
          state_d = S_GAP;
          dest_d  = S_ACTION;
        end else if (deck_count == 8'd0) begin
          state_d = S_GAP;
          dest_d  = (discard_count != 8'd0) ? S_SHUFFLE : S_ACTION;
        end
      end
      S_SHUFFLE: begin
        if (end_mode) begin
          state_d = S_GAP;
          dest_d  = S_DRAW;
        end
      end
      S_ACTION: begin
        if (plus_buy && buys_left_q != 4'd15) begin
          buys_left_d = buys_left_q + 4'd1;
        end
        if (but_end) begin
          state_d = S_BUY;
        end
      end
      S_BUY: begin
        buys_left_d = buys_after;
        if (buys_after == 4'd0 || but_end) begin
          state_d = S_GAP;
          dest_d  = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        if (end_mode) begin
          turn_count_d = turn_count_q + 8'd1;
          draw_left_d  = HAND_L;
          buys_left_d  = BUYS_L;
          state_d      = S_GAP;
          dest_d       = S_DRAW;
        end
      end
      S_GAP: begin
        state_d = dest_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      S_DRAW:    mode_d = MODE_DRAW;
      S_SHUFFLE: mode_d = MODE_SHUFFLE;
      S_BUY:     mode_d = MODE_BUY;
      S_CLEANUP: mode_d = MODE_CLEANUP;
      default:   mode_d = MODE_IDLE;
    endcase
    can_buy_d = (state_d == S_BUY) && (buys_left_d != 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      dest_q       <= S_IDLE;
      draw_left_q  <= 4'd0;
      buys_left_q  <= 4'd0;
      turn_count_q <= 8'd0;
      mode_q       <= MODE_IDLE;
      can_buy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      draw_left_q  <= draw_left_d;
      buys_left_q  <= buys_left_d;
      turn_count_q <= turn_count_d;
      mode_q       <= mode_d;
      can_buy_q    <= can_buy_d;
    end
  end

  assign mode       = mode_q;
  assign can_buy    = can_buy_q;
  assign phase      = state_q;
  assign buys_left  = buys_left_q;
  assign turn_count = turn_count_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: scripted turns with a queue of expected outputs per cycle.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, but_end, plus_buy, end_mode, next_card;
  logic [7:0] deck_count, discard_count;
  logic [2:0] mode;
  logic       can_buy;
  logic [2:0] phase;
  logic [3:0] buys_left;
  logic [7:0] turn_count;

  always #5 clk = ~clk;

  turn_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .but_end       (but_end),
    .plus_buy      (plus_buy),
    .end_mode      (end_mode),
    .next_card     (next_card),
    .deck_count    (deck_count),
    .discard_count (discard_count),
    .mode          (mode),
    .can_buy       (can_buy),
    .phase         (phase),
    .buys_left     (buys_left),
    .turn_count    (turn_count)
  );

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [2:0] md;
    logic       cb;
    logic [3:0] bl;
    logic [7:0] tc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [2:0] ph, input logic [2:0] md,
                          input logic cb, input logic [3:0] bl, input logic [7:0] tc);
    sb_q.push_back('{tag: tag, ph: ph, md: md, cb: cb, bl: bl, tc: tc});
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.tag, ".phase"},      32'(phase),      32'(e.ph));
    chk({e.tag, ".mode"},       32'(mode),       32'(e.md));
    chk({e.tag, ".can_buy"},    32'(can_buy),    32'(e.cb));
    chk({e.tag, ".buys_left"},  32'(buys_left),  32'(e.bl));
    chk({e.tag, ".turn_count"}, 32'(turn_count), 32'(e.tc));
  endtask

  // Drive one cycle of pulses, record what the DUT must show after the edge, then compare.
  task automatic cyc(input string tag, input logic st, input logic be, input logic pb,
                     input logic em, input logic nc, input logic [2:0] ph, input logic [2:0] md,
                     input logic cb, input logic [3:0] bl, input logic [7:0] tc);
    @(negedge clk);
    start = st; but_end = be; plus_buy = pb; end_mode = em; next_card = nc;
    push_exp(tag, ph, md, cb, bl, tc);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic idle(input string tag, input logic [2:0] ph, input logic [2:0] md,
                      input logic cb, input logic [3:0] bl, input logic [7:0] tc);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ph, md, cb, bl, tc);
  endtask

  initial begin
    logic [3:0] bl_exp;
    reset = 1'b0; start = 1'b0; but_end = 1'b0; plus_buy = 1'b0;
    end_mode = 1'b0; next_card = 1'b0; deck_count = 8'd10; discard_count = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 3'd0, 3'd0, 1'b0, 4'd0, 8'd0);
    pop_cmp();
    @(negedge clk);
    reset = 1'b1;

    // Plain draw of a full hand; stray pulses during DRAW must do nothing.
    cyc("t2_start", 1, 0, 0, 0, 0, 3'd6, 3'd0, 0, 4'd1, 8'd0);
    idle("t2_draw", 3'd1, 3'd1, 0, 4'd1, 8'd0);
    cyc("t6_start_in_draw",   1, 0, 0, 0, 0, 3'd1, 3'd1, 0, 4'd1, 8'd0);
    cyc("t6_but_end_in_draw", 0, 1, 0, 0, 0, 3'd1, 3'd1, 0, 4'd1, 8'd0);
    cyc("t6_plus_in_draw",    0, 0, 1, 0, 0, 3'd1, 3'd1, 0, 4'd1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc("t2_card", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd0);
      deck_count = deck_count - 8'd1;
    end
    cyc("t2_card5", 0, 0, 0, 0, 1, 3'd6, 3'd0, 0, 4'd1, 8'd0);
    deck_count = deck_count - 8'd1;
    idle("t2_action", 3'd3, 3'd0, 0, 4'd1, 8'd0);

    // Action with extra buys, then spend all buys.
    cyc("t5_plus1",     0, 0, 1, 0, 0, 3'd3, 3'd0, 0, 4'd2, 8'd0);
    cyc("t5_plus2",     0, 0, 1, 0, 0, 3'd3, 3'd0, 0, 4'd3, 8'd0);
    cyc("t5_to_buy",    0, 1, 0, 0, 0, 3'd4, 3'd2, 1, 4'd3, 8'd0);
    cyc("t5_em_in_buy", 0, 0, 0, 1, 0, 3'd4, 3'd2, 1, 4'd3, 8'd0);
    cyc("t5_gain1",     0, 0, 0, 0, 1, 3'd4, 3'd2, 1, 4'd2, 8'd0);
    cyc("t5_gain2",     0, 0, 0, 0, 1, 3'd4, 3'd2, 1, 4'd1, 8'd0);
    cyc("t5_gain3",     0, 0, 0, 0, 1, 3'd6, 3'd0, 0, 4'd0, 8'd0);
    idle("t5_cleanup",      3'd5, 3'd3, 0, 4'd0, 8'd0);
    idle("t5_cleanup_wait", 3'd5, 3'd3, 0, 4'd0, 8'd0);
    deck_count = 8'd2; discard_count = 8'd8;
    cyc("t5_cleanup_done", 0, 0, 0, 1, 0, 3'd6, 3'd0, 0, 4'd1, 8'd1);
    idle("t5_draw", 3'd1, 3'd1, 0, 4'd1, 8'd1);

    // Deck runs dry mid-draw: shuffle, then finish the hand.
    cyc("t3_card1", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd1);
    deck_count = 8'd1;
    cyc("t3_card2", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd1);
    deck_count = 8'd0;
    idle("t3_deck_empty",   3'd6, 3'd0, 0, 4'd1, 8'd1);
    idle("t3_shuffle",      3'd2, 3'd4, 0, 4'd1, 8'd1);
    idle("t3_shuffle_wait", 3'd2, 3'd4, 0, 4'd1, 8'd1);
    deck_count = 8'd8; discard_count = 8'd0;
    cyc("t3_shuffle_done", 0, 0, 0, 1, 0, 3'd6, 3'd0, 0, 4'd1, 8'd1);
    idle("t3_redraw", 3'd1, 3'd1, 0, 4'd1, 8'd1);
    cyc("t3_card3", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd1);
    cyc("t3_card4", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd1);
    cyc("t3_card5", 0, 0, 0, 0, 1, 3'd6, 3'd0, 0, 4'd1, 8'd1);
    deck_count = 8'd5;
    idle("t3_action", 3'd3, 3'd0, 0, 4'd1, 8'd1);

    // Gain and end-phase in the same cycle.
    cyc("t6_plus",   0, 0, 1, 0, 0, 3'd3, 3'd0, 0, 4'd2, 8'd1);
    cyc("t6_to_buy", 0, 1, 0, 0, 0, 3'd4, 3'd2, 1, 4'd2, 8'd1);
    cyc("t6_nc_be",  0, 1, 0, 0, 1, 3'd6, 3'd0, 0, 4'd1, 8'd1);
    idle("t6_cleanup", 3'd5, 3'd3, 0, 4'd1, 8'd1);
    deck_count = 8'd0; discard_count = 8'd0;
    cyc("t6_cleanup_done", 0, 0, 0, 1, 0, 3'd6, 3'd0, 0, 4'd1, 8'd2);

    // Empty deck and discard at draw entry: short hand, no shuffle.
    idle("t4_draw",       3'd1, 3'd1, 0, 4'd1, 8'd2);
    idle("t4_short_hand", 3'd6, 3'd0, 0, 4'd1, 8'd2);
    idle("t4_action",     3'd3, 3'd0, 0, 4'd1, 8'd2);

    // plus_buy saturates at 15.
    bl_exp = 4'd1;
    for (int i = 0; i < 16; i++) begin
      if (bl_exp != 4'd15) bl_exp = bl_exp + 4'd1;
      cyc("sat_plus", 0, 0, 1, 0, 0, 3'd3, 3'd0, 0, bl_exp, 8'd2);
    end
    cyc("sat_to_buy", 0, 1, 0, 0, 0, 3'd4, 3'd2, 1, 4'd15, 8'd2);
    cyc("sat_end_buy", 0, 1, 0, 0, 0, 3'd6, 3'd0, 0, 4'd15, 8'd2);
    idle("sat_cleanup", 3'd5, 3'd3, 0, 4'd15, 8'd2);
    deck_count = 8'd10;
    cyc("sat_cleanup_done", 0, 0, 0, 1, 0, 3'd6, 3'd0, 0, 4'd1, 8'd3);
    idle("t1_draw", 3'd1, 3'd1, 0, 4'd1, 8'd3);
    cyc("t1_card", 0, 0, 0, 0, 1, 3'd1, 3'd1, 0, 4'd1, 8'd3);

    // Reset asserted mid-DRAW takes effect immediately.
    @(negedge clk);
    reset = 1'b0;
    #1;
    push_exp("t1_async", 3'd0, 3'd0, 1'b0, 4'd0, 8'd0);
    pop_cmp();
    @(posedge clk);
    #1;
    push_exp("t1_edge", 3'd0, 3'd0, 1'b0, 4'd0, 8'd0);
    pop_cmp();
    @(negedge clk);
    reset = 1'b1;

    // Fresh turn after reset; card and end_mode together exit DRAW.
    cyc("r_start", 1, 0, 0, 0, 0, 3'd6, 3'd0, 0, 4'd1, 8'd0);
    idle("r_draw", 3'd1, 3'd1, 0, 4'd1, 8'd0);
    cyc("r_nc_em", 0, 0, 0, 1, 1, 3'd6, 3'd0, 0, 4'd1, 8'd0);
    idle("r_action", 3'd3, 3'd0, 0, 4'd1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
